// File: rtl/lifting_step_unit.sv
// lifting_step_unit
// Streaming fixed-point lifting stage for the 9/7 DWT row path. It runs one
// predict step (d = o + A*(e + e_next)) and then one update step
// (s = e + B*(d_prev + d)) on every lane. Each beat carries one {odd, even}
// pair per lane. Whole-sample symmetric extension is applied at both ends of
// the line, and the block supports full ready/valid backpressure.
//
// Ports
//   clk_i, rst_ni          rising-edge clock, asynchronous active-low reset
//   s_ready_o/s_valid_i    input handshake
//   s_sof_i / s_eol_i      input beat is first / last pair of a line
//   s_data_i               lane c at [c*2W +: 2W] = {odd, even}
//   m_ready_i/m_valid_o    output handshake
//   m_sof_o / m_eol_o      output is first / last result of a line
//   m_data_o               lane c at [c*2W +: 2W] = {d, s}
`timescale 1ns/1ps
module lifting_step_unit #(
  parameter int  DataWidth = 16,
  parameter int  Point     = 10,
  parameter int  Channels  = 1,
  parameter real Alpha     = -1.586134342,
  parameter real Beta      = -0.052980118,
  parameter bit  Saturate  = 1'b1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  output logic                            s_ready_o,
  input  logic                            s_valid_i,
  input  logic                            s_sof_i,
  input  logic                            s_eol_i,
  input  logic [Channels*2*DataWidth-1:0] s_data_i,
  input  logic                            m_ready_i,
  output logic                            m_valid_o,
  output logic                            m_sof_o,
  output logic                            m_eol_o,
  output logic [Channels*2*DataWidth-1:0] m_data_o
);

  localparam int W     = DataWidth;
  localparam int LW    = 2 * DataWidth;
  localparam int PW    = DataWidth + 33;
  localparam int CoefA = $rtoi(Alpha * real'(1 << Point));
  localparam int CoefB = $rtoi(Beta * real'(1 << Point));
  localparam logic signed [W+1:0] MaxWide = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] MinWide = {3'b111, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

  // Full-precision product of a (W+1)-bit pair sum and a coefficient, floored
  // by Point and then reduced to the (W+2)-bit width of the final adder.
  function automatic logic signed [W+1:0] scale(input logic signed [W:0]  sum,
                                                 input logic signed [31:0] coef);
    logic signed [PW-1:0] prod;
    prod = PW'(sum) * PW'(coef);
    return (W+2)'(prod >>> Point);
  endfunction

  function automatic logic signed [W-1:0] fit(input logic signed [W+1:0] x);
    if (Saturate && (x > MaxWide)) return MaxWide[W-1:0];
    if (Saturate && (x < MinWide)) return MinWide[W-1:0];
    return x[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] predict(input logic signed [W-1:0] o,
                                                   input logic signed [W-1:0] e0,
                                                   input logic signed [W-1:0] e1);
    logic signed [W:0]   sum;
    logic signed [W+1:0] acc;
    sum = {e0[W-1], e0} + {e1[W-1], e1};
    acc = {{2{o[W-1]}}, o} + scale(sum, CoefA);
    return fit(acc);
  endfunction

  function automatic logic signed [W-1:0] update(input logic signed [W-1:0] e,
                                                  input logic signed [W-1:0] dl,
                                                  input logic signed [W-1:0] dr);
    logic signed [W:0]   sum;
    logic signed [W+1:0] acc;
    sum = {dl[W-1], dl} + {dr[W-1], dr};
    acc = {{2{e[W-1]}}, e} + scale(sum, CoefB);
    return fit(acc);
  endfunction

  state_t state_q, state_d;
  logic   out_free, ready, accept, load, restart;

  logic signed [W-1:0] held_e_p0 [Channels];
  logic signed [W-1:0] held_o_p0 [Channels];
  logic signed [W-1:0] d_prev_p0 [Channels];
  logic                first_p0;

  logic signed [W-1:0] e_next [Channels];
  logic signed [W-1:0] d_new  [Channels];
  logic signed [W-1:0] d_left [Channels];
  logic signed [W-1:0] s_new  [Channels];
  logic [Channels*LW-1:0] word;

  logic                   vld_p1, sof_p1, eol_p1;
  logic [Channels*LW-1:0] data_p1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // The output register is "free" when it is empty or being drained this
  // cycle, so a new load can replace a departing beat with no bubble.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    restart  = 1'b0;
    out_free = ~vld_p1 | m_ready_i;
    ready    = rst_ni & (state_q != FLUSH) & out_free;
    accept   = s_valid_i & ready;
    case (state_q)
      IDLE: begin
        if (accept) begin
          restart = 1'b1;
          state_d = s_eol_i ? FLUSH : HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          // A sof here abandons the held pair: it never gets a successor.
          restart = s_sof_i;
          load    = ~s_sof_i;
          state_d = s_eol_i ? FLUSH : HOLD;
        end
      end
      FLUSH: begin
        if (out_free) begin
          load    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_ready_o = ready;

  // Stage p0 -> p1: held pair plus the next even sample produce one result.
  // In FLUSH the next even is the held one (right-end extension); on the first
  // result of a line d_prev is d itself (left-end extension).
  always_comb begin
    word = '0;
    for (int c = 0; c < Channels; c++) begin
      e_next[c] = (state_q == FLUSH) ? held_e_p0[c] : s_data_i[c*LW +: W];
      d_new[c]  = predict(held_o_p0[c], held_e_p0[c], e_next[c]);
      d_left[c] = first_p0 ? d_new[c] : d_prev_p0[c];
      s_new[c]  = update(held_e_p0[c], d_left[c], d_new[c]);
      word[c*LW +: LW] = {d_new[c], s_new[c]};
    end
  end

  // Stage p0: held pair and previous d.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int c = 0; c < Channels; c++) begin
        held_e_p0[c] <= s_data_i[c*LW +: W];
        held_o_p0[c] <= s_data_i[c*LW+W +: W];
      end
    end
    if (load) begin
      for (int c = 0; c < Channels; c++) d_prev_p0[c] <= d_new[c];
    end
  end

  // Stage p1: output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      first_p0 <= 1'b1;
      vld_p1   <= 1'b0;
      sof_p1   <= 1'b0;
      eol_p1   <= 1'b0;
      data_p1  <= '0;
    end else begin
      if (restart)   first_p0 <= 1'b1;
      else if (load) first_p0 <= 1'b0;
      if (load) begin
        vld_p1  <= 1'b1;
        sof_p1  <= first_p0;
        eol_p1  <= (state_q == FLUSH);
        data_p1 <= word;
      end else if (m_ready_i) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign m_valid_o = vld_p1;
  assign m_sof_o   = sof_p1;
  assign m_eol_o   = eol_p1;
  assign m_data_o  = data_p1;

endmodule

// File: tb/tb_lifting_step_unit.sv
`timescale 1ns/1ps
module tb_lifting_step_unit;
  localparam int W  = 16;
  localparam int P  = 10;
  localparam int CH = 4;
  localparam int LW = 2 * W;
  localparam longint CA  = -512;  // -0.5
  localparam longint CB  = 256;   // 0.25
  localparam longint CA2 = 512;   // +0.5

  typedef struct packed {
    logic              sof;
    logic              eol;
    logic [CH*LW-1:0]  main;
    logic [LW-1:0]     w;
    logic [LW-1:0]     c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0, s_sof = 1'b0, s_eol = 1'b0;
  logic [CH*LW-1:0] s_data = '0;
  logic m_ready = 1'b1;
  logic s_ready, m_valid, m_sof, m_eol;
  logic [CH*LW-1:0] m_data;
  logic w_ready, w_valid, w_sof, w_eol;
  logic [LW-1:0] w_data;
  logic c_ready, c_valid, c_sof, c_eol;
  logic [LW-1:0] c_data;

  exp_t exp_q[$];
  exp_t got_q[$];
  logic [CH*LW-1:0] line_q[$];
  int n_vec = 0;
  int n_err = 0;
  int rdy_mode = 1;

  always #5 clk = ~clk;

  lifting_step_unit #(.DataWidth(W), .Point(P), .Channels(CH), .Alpha(-0.5),
                      .Beta(0.25), .Saturate(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .s_ready_o(s_ready), .s_valid_i(s_valid),
    .s_sof_i(s_sof), .s_eol_i(s_eol), .s_data_i(s_data), .m_ready_i(m_ready),
    .m_valid_o(m_valid), .m_sof_o(m_sof), .m_eol_o(m_eol), .m_data_o(m_data));

  lifting_step_unit #(.DataWidth(W), .Point(P), .Channels(1), .Alpha(0.5),
                      .Beta(0.25), .Saturate(1'b0)) dut_wrap (
    .clk_i(clk), .rst_ni(rst_n), .s_ready_o(w_ready), .s_valid_i(s_valid),
    .s_sof_i(s_sof), .s_eol_i(s_eol), .s_data_i(s_data[LW-1:0]), .m_ready_i(m_ready),
    .m_valid_o(w_valid), .m_sof_o(w_sof), .m_eol_o(w_eol), .m_data_o(w_data));

  lifting_step_unit #(.DataWidth(W), .Point(P), .Channels(1), .Alpha(0.5),
                      .Beta(0.25), .Saturate(1'b1)) dut_clamp (
    .clk_i(clk), .rst_ni(rst_n), .s_ready_o(c_ready), .s_valid_i(s_valid),
    .s_sof_i(s_sof), .s_eol_i(s_eol), .s_data_i(s_data[LW-1:0]), .m_ready_i(m_ready),
    .m_valid_o(c_valid), .m_sof_o(c_sof), .m_eol_o(c_eol), .m_data_o(c_data));

  // ---------------- reference model ----------------
  function automatic longint wrapn(input longint x, input int n);
    longint m, r;
    m = longint'(1) << n;
    r = x & (m - 1);
    return (r >= (m >> 1)) ? r - m : r;
  endfunction

  function automatic longint fitv(input longint x, input bit sat);
    if (!sat) return wrapn(x, W);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic longint ev(input logic [CH*LW-1:0] b, input int c);
    return longint'($signed(b[c*LW +: W]));
  endfunction

  function automatic longint od(input logic [CH*LW-1:0] b, input int c);
    return longint'($signed(b[c*LW+W +: W]));
  endfunction

  // d_k of the current line; past the last pair the even sample is mirrored.
  function automatic longint d_of(input int k, input int c, input longint a, input bit sat);
    int kn;
    longint sum;
    kn  = (k + 1 < line_q.size()) ? k + 1 : k;
    sum = ev(line_q[k], c) + ev(line_q[kn], c);
    return fitv(wrapn(od(line_q[k], c) + ((sum * a) >>> P), W + 2), sat);
  endfunction

  function automatic longint s_of(input int k, input int c, input longint a,
                                  input longint b, input bit sat);
    longint dn, dp;
    dn = d_of(k, c, a, sat);
    dp = (k == 0) ? dn : d_of(k - 1, c, a, sat);
    return fitv(wrapn(ev(line_q[k], c) + (((dp + dn) * b) >>> P), W + 2), sat);
  endfunction

  task automatic push_out(input int k, input logic sof, input logic eol);
    exp_t e;
    e.sof = sof;
    e.eol = eol;
    e.main = '0;
    for (int c = 0; c < CH; c++) begin
      e.main[c*LW +: W]   = W'(s_of(k, c, CA, CB, 1'b1));
      e.main[c*LW+W +: W] = W'(d_of(k, c, CA, 1'b1));
    end
    e.w = {W'(d_of(k, 0, CA2, 1'b0)), W'(s_of(k, 0, CA2, CB, 1'b0))};
    e.c = {W'(d_of(k, 0, CA2, 1'b1)), W'(s_of(k, 0, CA2, CB, 1'b1))};
    exp_q.push_back(e);
  endtask

  task automatic model_accept(input logic [CH*LW-1:0] b, input logic sof, input logic eol);
    int k;
    if (sof) line_q.delete();
    line_q.push_back(b);
    k = line_q.size() - 1;
    if (k >= 1) push_out(k - 1, (k - 1) == 0, 1'b0);
    if (eol) begin
      push_out(k, k == 0, 1'b1);
      line_q.delete();
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input longint act, input longint expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [CH*LW-1:0] b, input logic sof, input logic eol);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_sof   = sof;
    s_eol   = eol;
    s_data  = b;
    forever begin
      @(negedge clk);
      if (s_ready) begin
        model_accept(b, sof, eol);
        break;
      end
      t++;
      if (t > 300) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: s_ready stayed %0b for %0d cycles", s_ready, t);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_valid) && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  function automatic logic [CH*LW-1:0] ramp(input int i);
    logic [CH*LW-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      r[c*LW +: W]   = W'(2 * i * 1024 * (c + 1) - c * 5000);
      r[c*LW+W +: W] = W'((2 * i + 1) * 1024 * (c + 1) - c * 5000);
    end
    return r;
  endfunction

  function automatic logic [CH*LW-1:0] rnd_beat();
    logic [CH*LW-1:0] r;
    for (int c = 0; c < CH; c++) r[c*LW +: LW] = $urandom();
    return r;
  endfunction

  // ---------------- downstream ready ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 2) m_ready = 1'($urandom_range(0, 1));
      else               m_ready = (rdy_mode == 1);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    exp_t a, e, pv;
    logic ph;
    ph = 1'b0;
    pv = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ph = 1'b0;
        continue;
      end
      a.sof = m_sof; a.eol = m_eol; a.main = m_data; a.w = w_data; a.c = c_data;
      n_vec++;
      if ({w_valid, c_valid, w_ready, c_ready} !== {m_valid, m_valid, s_ready, s_ready}) begin
        n_err++;
        $display("FAIL lockstep: got %b expected %b", {w_valid, c_valid, w_ready, c_ready},
                 {m_valid, m_valid, s_ready, s_ready});
      end
      if (ph) begin
        n_vec++;
        if (!m_valid || a !== pv) begin
          n_err++;
          $display("FAIL hold_stable: valid %0b got %h held %h", m_valid, a, pv);
        end
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got %h with nothing expected", a);
        end else begin
          e = exp_q.pop_front();
          n_vec++;
          if (a !== e) begin
            n_err++;
            $display("FAIL beat: got %h expected %h", a, e);
          end
          got_q.push_back(a);
        end
      end
      ph = m_valid && !m_ready;
      pv = a;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [CH*LW-1:0] b;
    int s1[4];
    int d1[4];
    int lens[3];
    s1 = '{0, 2048, 4096, 6400};
    d1 = '{0, 0, 0, 1024};
    lens = '{1, 2, 17};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", m_valid, 0);
    chk("rst_sof", m_sof, 0);
    chk("rst_eol", m_eol, 0);
    chk("rst_data_nonzero", |m_data, 0);
    chk("rst_ready", s_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", s_ready, 1);
    @(posedge clk);
    #1;

    // Ramp line x = 0..7 on lane 0, distinct ramps on other lanes.
    got_q.delete();
    for (int i = 0; i < 4; i++) send(ramp(i), i == 0, i == 3);
    @(negedge clk);
    chk("flush_stall", s_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ready_after_flush", s_ready, 1);
    @(posedge clk);
    #1;
    drain();
    chk("ramp_count", got_q.size(), 4);
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      chk($sformatf("ramp_s%0d", i), longint'($signed(got_q[i].main[W-1:0])), s1[i]);
      chk($sformatf("ramp_d%0d", i), longint'($signed(got_q[i].main[LW-1:W])), d1[i]);
      chk($sformatf("ramp_sof%0d", i), got_q[i].sof, i == 0);
      chk($sformatf("ramp_eol%0d", i), got_q[i].eol, i == 3);
    end

    // Single-pair line: even 2.0, odd 3.0.
    got_q.delete();
    b = rnd_beat();
    b[LW-1:0] = {16'sd3072, 16'sd2048};
    send(b, 1'b1, 1'b1);
    drain();
    chk("single_count", got_q.size(), 1);
    chk("single_d", longint'($signed(got_q[0].main[LW-1:W])), 1024);
    chk("single_s", longint'($signed(got_q[0].main[W-1:0])), 2560);
    chk("single_sof", got_q[0].sof, 1);
    chk("single_eol", got_q[0].eol, 1);

    // even = odd = 31.0 with Alpha = +0.5: clamp versus wrap.
    got_q.delete();
    b = rnd_beat();
    b[LW-1:0] = {16'sd31744, 16'sd31744};
    send(b, 1'b1, 1'b1);
    drain();
    chk("clamp_d", longint'($signed(got_q[0].c[LW-1:W])), 32767);
    chk("wrap_d", longint'($signed(got_q[0].w[LW-1:W])), -2048);

    // Random backpressure, back-to-back lines of 1, 2, 17 pairs, then a line
    // that starts without sof.
    rdy_mode = 2;
    idle(2);
    foreach (lens[l]) begin
      for (int i = 0; i < lens[l]; i++) send(rnd_beat(), i == 0, i == lens[l] - 1);
    end
    for (int i = 0; i < 5; i++) begin
      send(rnd_beat(), 1'b0, i == 4);
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    drain();

    // Line A abandoned after 3 pairs by the sof of line B (5 pairs).
    got_q.delete();
    for (int i = 0; i < 3; i++) send(rnd_beat(), i == 0, 1'b0);
    for (int i = 0; i < 5; i++) send(rnd_beat(), i == 0, i == 4);
    drain();
    chk("abort_count", got_q.size(), 7);
    chk("abort_a_no_eol", got_q[1].eol, 0);
    chk("abort_b_sof", got_q[2].sof, 1);
    chk("abort_b_eol", got_q[6].eol, 1);

    // Reset in the middle of a line with an output waiting.
    rdy_mode = 0;
    idle(2);
    send(rnd_beat(), 1'b1, 1'b0);
    send(rnd_beat(), 1'b0, 1'b0);
    chk("pre_reset_valid", m_valid, 1);
    rst_n = 1'b0;
    exp_q.delete();
    line_q.delete();
    #1;
    chk("reset_drops_valid", m_valid, 0);
    chk("reset_ready_low", s_ready, 0);
    idle(2);
    rst_n = 1'b1;
    rdy_mode = 2;
    idle(2);
    for (int i = 0; i < 6; i++) send(rnd_beat(), i == 0, i == 5);
    drain();

    chk("final_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
